// File: rtl/mult_div_unit.sv
// MIPS EX-stage multiply/divide unit: owns HI/LO, runs mult/div as timed multi-cycle
// operations (result computed at accept, committed when the countdown expires) and mthi/mtlo.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] div_a, div_b, div_b_safe, q_u, r_u, quot, rem;

    // Signed product: sign-extend both operands to 64 bits; the low 64 bits of the
    // unsigned product are then the two's complement result.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned divider on magnitudes; signs re-applied afterwards so that
    // 0x80000000 / -1 falls out as 0x80000000 without overflow.
    assign div_signed = (Op == OP_DIV);
    assign div_a      = (div_signed && A[31]) ? (~A + 32'd1) : A;
    assign div_b      = (div_signed && B[31]) ? (~B + 32'd1) : B;
    assign div_b_safe = (B == 32'd0) ? 32'd1 : div_b;
    assign q_u        = div_a / div_b_safe;
    assign r_u        = div_a % div_b_safe;
    assign quot       = (div_signed && (A[31] ^ B[31])) ? (~q_u + 32'd1) : q_u;
    assign rem        = (div_signed && A[31]) ? (~r_u + 32'd1) : r_u;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            {hi_tmp_d, lo_tmp_d} = (Op == OP_MULT) ? prod_s : prod_u;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (B == 32'd0) begin
                                hi_tmp_d = hi_q;
                                lo_tmp_d = lo_q;
                            end else begin
                                hi_tmp_d = rem;
                                lo_tmp_d = quot;
                            end
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Commands arriving while running are dropped, never queued.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign Busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, hand-built corner sequences and
// random operations checked against a 64-bit arithmetic reference model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;
    vec_t vecs[5];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Op(Op),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int busy_len(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Reference: plain 64-bit arithmetic (SV division truncates toward zero, % follows dividend).
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return 64'(ua * ub);
            3'd3: begin
                if (b == 0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return {hi, lo};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd5: return {a, lo};
            3'd6: return {hi, a};
            default: return {hi, lo};
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; Op = op; A = a; B = b;
        tick();
        Start = 1'b0; Op = 3'd0;
    endtask

    // Issue one command, check Busy for exactly N cycles with HI/LO held, then the result.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = busy_len(op);
        issue(op, a, b);
        for (int i = 0; i < n; i++) begin
            check({name, " busy"}, 32'(Busy), 32'd1);
            check({name, " hi_hold"}, HI, m_hi);
            check({name, " lo_hold"}, LO, m_lo);
            tick();
        end
        check({name, " busy_end"}, 32'(Busy), 32'd0);
        check({name, " hi"}, HI, exp_hi);
        check({name, " lo"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        logic [63:0] r;
        logic [2:0]  op;
        logic [31:0] a, b;

        vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
        vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

        reset = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset busy", 32'(Busy), 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);

        // mthi then mtlo on consecutive edges
        Start = 1'b1; Op = 3'd5; A = 32'h12345678;
        tick();
        check("mthi hi", HI, 32'h12345678);
        check("mthi busy", 32'(Busy), 32'd0);
        Op = 3'd6; A = 32'h9;
        tick();
        Start = 1'b0; Op = 3'd0;
        check("mtlo lo", LO, 32'h9);
        check("mtlo hi", HI, 32'h12345678);
        check("mtlo busy", 32'(Busy), 32'd0);
        m_hi = 32'h12345678;
        m_lo = 32'h9;

        // divide by zero leaves preloaded HI/LO
        run_op("pre_hi", 3'd5, 32'hA, 32'd0, 32'hA, m_lo);
        run_op("pre_lo", 3'd6, 32'hB, 32'd0, 32'hA, 32'hB);
        run_op("div0", 3'd3, 32'h1234, 32'd0, 32'hA, 32'hB);

        // mthi during mult busy cycle 2 is ignored
        issue(3'd1, 32'd7, 32'hFFFFFFFD);
        tick();
        Start = 1'b1; Op = 3'd5; A = 32'hDEADBEEF;
        tick();
        Start = 1'b0; Op = 3'd0;
        for (int i = 2; i < 5; i++) begin
            check("ign busy", 32'(Busy), 32'd1);
            check("ign hi_hold", HI, 32'hA);
            tick();
        end
        check("ign busy_end", 32'(Busy), 32'd0);
        check("ign hi", HI, 32'hFFFFFFFF);
        check("ign lo", LO, 32'hFFFFFFEB);
        m_hi = 32'hFFFFFFFF;
        m_lo = 32'hFFFFFFEB;

        // reset at div busy cycle 4 aborts; no late write
        issue(3'd4, 32'd100, 32'd3);
        repeat (3) tick();
        check("abort pre busy", 32'(Busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(Busy), 32'd0);
        check("abort hi", HI, 32'd0);
        check("abort lo", LO, 32'd0);
        repeat (12) tick();
        check("abort late busy", 32'(Busy), 32'd0);
        check("abort late hi", HI, 32'd0);
        check("abort late lo", LO, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // reset wins over Start on the same edge
        run_op("pre2", 3'd5, 32'h55, 32'd0, 32'h55, 32'd0);
        reset = 1'b1; Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd4;
        tick();
        reset = 1'b0; Start = 1'b0; Op = 3'd0;
        check("rst_start busy", 32'(Busy), 32'd0);
        check("rst_start hi", HI, 32'd0);
        tick();
        check("rst_start busy2", 32'(Busy), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            r = ref_result(op, a, b, m_hi, m_lo);
            run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, r[63:32], r[31:0]);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
